// File: rtl/ysyx_22041071_pc_gen_pkg.sv
// Shared constants and FSM encoding for the IF-stage PC generator.
package ysyx_22041071_pc_gen_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam logic [ADDR_W-1:0] START_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        PcgBoot = 2'd0,
        PcgRun  = 2'd1,
        PcgHalt = 2'd2
    } pcg_state_e;

    // Redirect targets are forced onto a word boundary; misalignment is only flagged.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22041071_pc_gen.sv
// Fetch PC generator: producer side of the IF valid/ready handshake with boot hold-off,
// EX redirects, WB halt and an accepted-fetch performance counter.
module ysyx_22041071_pc_gen
    import ysyx_22041071_pc_gen_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = START_ADDR,
    parameter int unsigned       BOOT_CYCLES = 4,
    parameter int unsigned       CNT_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready1,
    input  logic              brch_sel,
    input  logic [ADDR_W-1:0] brch_pc,
    input  logic              halt,
    output logic              valid1,
    output logic [ADDR_W-1:0] PC1,
    output logic              redirected,
    output logic              misalign,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [3:0] BootInit = 4'(BOOT_CYCLES - 1);

    pcg_state_e state_q;
    logic [3:0] boot_cnt_q;
    logic       handshake;
    logic       count_en;

    assign handshake = valid1 & ready1;
    // halt outranks the handshake, so a fetch offered in the halting cycle is not counted.
    assign count_en  = (state_q == PcgRun) & handshake & ~halt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PcgBoot;
            boot_cnt_q <= BootInit;
            PC1        <= RESET_PC;
            valid1     <= 1'b0;
            redirected <= 1'b0;
            misalign   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            redirected <= 1'b0;
            misalign   <= 1'b0;
            unique case (state_q)
                PcgBoot: begin
                    if (halt) begin
                        state_q <= PcgHalt;
                        halted  <= 1'b1;
                    end else if (boot_cnt_q == 4'd0) begin
                        state_q <= PcgRun;
                        valid1  <= 1'b1;
                    end else begin
                        boot_cnt_q <= boot_cnt_q - 4'd1;
                    end
                end
                PcgRun: begin
                    if (halt) begin
                        state_q <= PcgHalt;
                        valid1  <= 1'b0;
                        halted  <= 1'b1;
                    end else if (brch_sel) begin
                        // A redirect flushes the pending offer even under backpressure.
                        PC1        <= align_pc(brch_pc);
                        redirected <= 1'b1;
                        misalign   <= |brch_pc[1:0];
                    end else if (handshake) begin
                        PC1 <= PC1 + 64'd4;
                    end
                end
                PcgHalt: begin
                    valid1 <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state_q <= PcgHalt;
                    valid1  <= 1'b0;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= '0;
        end else if (count_en) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_pc_gen.sv
// Self-checking bench for the PC generator: directed scenarios plus randomized traffic
// checked against a cycle-count based reference model.
module tb_ysyx_22041071_pc_gen;

    localparam int unsigned BOOT = 4;
    localparam logic [63:0] RPC  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready1;
    logic        brch_sel;
    logic [63:0] brch_pc;
    logic        halt;
    logic        valid1;
    logic [63:0] PC1;
    logic        redirected;
    logic        misalign;
    logic        halted;
    logic [63:0] fetch_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cycles since reset release decide boot, a sticky flag decides halt.
    int          m_cycles;
    bit          m_halted;
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    bit          m_red;
    bit          m_mis;
    logic [63:0] saved_pc;
    logic [63:0] saved_cnt;

    ysyx_22041071_pc_gen #(
        .RESET_PC   (RPC),
        .BOOT_CYCLES(BOOT),
        .CNT_W      (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ready1    (ready1),
        .brch_sel  (brch_sel),
        .brch_pc   (brch_pc),
        .halt      (halt),
        .valid1    (valid1),
        .PC1       (PC1),
        .redirected(redirected),
        .misalign  (misalign),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_live();
        return !m_halted && (m_cycles >= int'(BOOT));
    endfunction

    task automatic check_all();
        check("valid1", {63'b0, valid1}, {63'b0, m_live()});
        check("PC1", PC1, m_pc);
        check("redirected", {63'b0, redirected}, {63'b0, m_red});
        check("misalign", {63'b0, misalign}, {63'b0, m_mis});
        check("halted", {63'b0, halted}, {63'b0, m_halted});
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_cycles = 0;
        m_halted = 0;
        m_pc     = RPC;
        m_cnt    = 0;
        m_red    = 0;
        m_mis    = 0;
    endtask

    // Advance model by one edge using current inputs, then clock the DUT and compare.
    task automatic cycle();
        bit live;
        live  = m_live();
        m_red = 0;
        m_mis = 0;
        if (!m_halted) begin
            if (halt) begin
                m_halted = 1;
            end else if (live) begin
                if (ready1) m_cnt = m_cnt + 1;
                if (brch_sel) begin
                    m_pc  = brch_pc - (brch_pc % 4);
                    m_red = 1;
                    m_mis = (brch_pc % 4) != 0;
                end else if (ready1) begin
                    m_pc = m_pc + 4;
                end
            end
        end
        if (m_cycles < 1000) m_cycles++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit r, input bit b, input logic [63:0] bp, input bit h);
        ready1   = r;
        brch_sel = b;
        brch_pc  = bp;
        halt     = h;
    endtask

    // Reset is asserted between edges and checked before the next edge arrives.
    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Boot window then first fetches.
        for (int i = 0; i < int'(BOOT); i++) begin
            check("boot_valid", {63'b0, valid1}, 64'd0);
            cycle();
        end
        check("first_pc", PC1, 64'h8000_0000);
        cycle();
        check("pc_plus4", PC1, 64'h8000_0004);
        cycle();
        check("pc_plus8", PC1, 64'h8000_0008);
        check("cnt_two", fetch_cnt, 64'd2);
        cycle();
        cycle();

        // Backpressure at 0x80000010.
        check("bp_start", PC1, 64'h8000_0010);
        set_in(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        check("bp_hold", PC1, 64'h8000_0010);
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        cycle();
        check("bp_release", PC1, 64'h8000_0014);

        // Redirect under stall, then misaligned redirect with handshake.
        saved_cnt = fetch_cnt;
        set_in(1'b0, 1'b1, 64'h8000_0100, 1'b0);
        cycle();
        check("redir_pc", PC1, 64'h8000_0100);
        check("redir_cnt", fetch_cnt, saved_cnt);
        set_in(1'b1, 1'b1, 64'h8000_0102, 1'b0);
        cycle();
        check("mis_pc", PC1, 64'h8000_0100);
        check("mis_flag", {63'b0, misalign}, 64'd1);
        check("mis_cnt", fetch_cnt, saved_cnt + 64'd1);
        set_in(1'b0, 1'b0, 64'h0, 1'b0);
        cycle();

        // PC wrap at the top of the address space.
        set_in(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        cycle();
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        cycle();
        check("pc_wrap", PC1, 64'h0);

        // Randomized traffic in RUN.
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   {$urandom, $urandom}, 1'b0);
            cycle();
        end

        // Halt beats a simultaneous redirect and freezes everything.
        saved_pc  = PC1;
        saved_cnt = fetch_cnt;
        set_in(1'b1, 1'b1, 64'h8000_0400, 1'b1);
        cycle();
        check("halt_pc", PC1, saved_pc);
        check("halt_flag", {63'b0, halted}, 64'd1);
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cycle();
        end
        check("halt_frozen_pc", PC1, saved_pc);
        check("halt_frozen_cnt", fetch_cnt, saved_cnt);

        // Halt during boot.
        pulse_reset();
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        cycle();
        set_in(1'b1, 1'b0, 64'h0, 1'b1);
        cycle();
        set_in(1'b1, 1'b1, 64'h8000_0200, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        check("boot_halt_valid", {63'b0, valid1}, 64'd0);

        // Async reset mid-run, then randomized traffic with rare halts and resets.
        pulse_reset();
        set_in(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 8; i++) cycle();
        check("run_before_reset", {63'b0, valid1}, 64'd1);
        #2;
        pulse_reset();
        check("async_pc", PC1, 64'h8000_0000);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       {$urandom, $urandom}, ($urandom_range(0, 59) == 0));
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
